// File: rtl/usb_rx_controller.sv
// usb_rx_controller: packet-level sequencer for the USB receive path.
// Validates sync and PID bytes, forwards DATA payload bytes to the RX FIFO,
// checks EOP framing/length and reports packet completion or error.
module usb_rx_controller #(
  parameter int          MAX_DATA  = 66,
  parameter logic [7:0]  SYNC_BYTE = 8'h80
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_d_edge,
  input  logic       i_eop,
  input  logic       i_shift_enable,
  input  logic       i_byte_received,
  input  logic [7:0] i_rcv_data,
  output logic       o_rx_transfer_active,
  output logic       o_flush,
  output logic       o_store_rx_packet_data,
  output logic [7:0] o_rx_packet_data,
  output logic [2:0] o_rx_packet,
  output logic       o_rx_packet_done,
  output logic       o_rx_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_TOKEN, S_DATA, S_HSK, S_EOP_WAIT, S_ERR_WAIT
  } state_t;

  localparam logic [6:0] MAX_CNT = 7'(MAX_DATA);

  state_t     r_state;
  logic [6:0] r_byte_cnt;
  logic [2:0] r_bit_cnt;
  logic       r_eop_seen;

  logic       r_active;
  logic       r_flush;
  logic       r_store;
  logic [7:0] r_data;
  logic [2:0] r_packet;
  logic       r_done;
  logic       r_error;

  // Next-state / event wires
  state_t     w_state_next;
  state_t     w_post_state;
  logic [6:0] w_post_cnt;
  logic       w_start;
  logic       w_err;
  logic       w_store;
  logic       w_accept;
  logic       w_finish;
  logic       w_pid_ok;
  logic       w_eop_evt;
  logic       w_len_ok;

  // PID decode wires
  logic       w_pid_cmpl_ok;
  logic       w_pid_known;
  logic [2:0] w_pid_code;
  state_t     w_pid_state;

  // Output next-value wires
  logic       w_active_next;
  logic       w_flush_next;
  logic       w_store_next;
  logic [7:0] w_data_next;
  logic [2:0] w_packet_next;
  logic       w_done_next;
  logic       w_error_next;

  // Decode the PID byte into a packet code and the state handling its body
  always_comb begin
    w_pid_cmpl_ok = (i_rcv_data[7:4] == ~i_rcv_data[3:0]);
    w_pid_known   = 1'b1;
    w_pid_code    = 3'd0;
    w_pid_state   = S_IDLE;
    case (i_rcv_data)
      8'hE1: begin w_pid_code = 3'd1; w_pid_state = S_TOKEN; end
      8'h69: begin w_pid_code = 3'd2; w_pid_state = S_TOKEN; end
      8'hC3: begin w_pid_code = 3'd3; w_pid_state = S_DATA;  end
      8'h4B: begin w_pid_code = 3'd4; w_pid_state = S_DATA;  end
      8'hD2: begin w_pid_code = 3'd5; w_pid_state = S_HSK;   end
      8'h5A: begin w_pid_code = 3'd6; w_pid_state = S_HSK;   end
      8'h1E: begin w_pid_code = 3'd7; w_pid_state = S_HSK;   end
      default: w_pid_known = 1'b0;
    endcase
  end

  // Next-state logic: byte handling first, then EOP check on the post-byte state
  always_comb begin
    w_state_next = r_state;
    w_post_state = r_state;
    w_post_cnt   = r_byte_cnt;
    w_start      = 1'b0;
    w_err        = 1'b0;
    w_store      = 1'b0;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    w_pid_ok     = 1'b0;
    w_len_ok     = 1'b0;
    w_eop_evt    = i_shift_enable && i_eop;

    // Byte phase
    if (i_byte_received) begin
      case (r_state)
        S_SYNC: begin
          if (i_rcv_data == SYNC_BYTE) w_post_state = S_PID;
          else                         w_err = 1'b1;
        end
        S_PID: begin
          if (w_pid_cmpl_ok && w_pid_known) begin
            w_pid_ok     = 1'b1;
            w_post_state = w_pid_state;
            w_post_cnt   = 7'd0;
          end else begin
            w_err = 1'b1;
          end
        end
        S_TOKEN: begin
          // Saturate so an overlong token cannot wrap back to a legal length
          if (r_byte_cnt != 7'h7F) w_post_cnt = r_byte_cnt + 7'd1;
        end
        S_DATA: begin
          if (r_byte_cnt >= MAX_CNT) begin
            w_err = 1'b1;
          end else begin
            w_store    = 1'b1;
            w_post_cnt = r_byte_cnt + 7'd1;
          end
        end
        S_HSK:   w_err = 1'b1;
        default: ;
      endcase
    end

    // EOP phase
    case (w_post_state)
      S_TOKEN: w_len_ok = (w_post_cnt == 7'd2);
      S_DATA:  w_len_ok = (w_post_cnt >= 7'd2) && (w_post_cnt <= MAX_CNT);
      S_HSK:   w_len_ok = (w_post_cnt == 7'd0);
      default: w_len_ok = 1'b0;
    endcase

    if (!w_err && w_eop_evt) begin
      case (w_post_state)
        S_SYNC, S_PID: w_err = 1'b1;
        S_TOKEN, S_DATA, S_HSK: begin
          if ((r_bit_cnt != 3'd0) || !w_len_ok) w_err = 1'b1;
          else                                  w_accept = 1'b1;
        end
        default: ;
      endcase
    end

    // A byte that errors must not also be stored
    if (w_err) w_store = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_d_edge) begin
          w_start      = 1'b1;
          w_state_next = S_SYNC;
        end
      end
      S_EOP_WAIT: begin
        if (!i_eop) begin
          w_finish     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_ERR_WAIT: begin
        if (r_eop_seen && !i_eop) begin
          w_finish     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        if (w_err)         w_state_next = S_ERR_WAIT;
        else if (w_accept) w_state_next = S_EOP_WAIT;
        else               w_state_next = w_post_state;
      end
    endcase
  end

  // Output next-values derived from the packet events of this cycle
  always_comb begin
    w_active_next = r_active;
    w_flush_next  = 1'b0;
    w_store_next  = 1'b0;
    w_data_next   = r_data;
    w_packet_next = r_packet;
    w_done_next   = 1'b0;
    w_error_next  = r_error;
    if (w_start) begin
      w_active_next = 1'b1;
      w_flush_next  = 1'b1;
      w_error_next  = 1'b0;
      w_packet_next = 3'd0;
    end
    if (w_pid_ok) w_packet_next = w_pid_code;
    if (w_store) begin
      w_store_next = 1'b1;
      w_data_next  = i_rcv_data;
    end
    if (w_accept) w_done_next = 1'b1;
    if (w_err) begin
      w_error_next  = 1'b1;
      w_packet_next = 3'd0;
    end
    if (w_finish) w_active_next = 1'b0;
  end

  // State, counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= 7'd0;
      r_bit_cnt  <= 3'd0;
      r_eop_seen <= 1'b0;
      r_active   <= 1'b0;
      r_flush    <= 1'b0;
      r_store    <= 1'b0;
      r_data     <= 8'd0;
      r_packet   <= 3'd0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_active <= w_active_next;
      r_flush  <= w_flush_next;
      r_store  <= w_store_next;
      r_data   <= w_data_next;
      r_packet <= w_packet_next;
      r_done   <= w_done_next;
      r_error  <= w_error_next;

      r_byte_cnt <= w_start ? 7'd0 : w_post_cnt;

      // Bit position within the current byte; a coinciding strobe is bit 1 of the next byte
      if (w_start)
        r_bit_cnt <= 3'd0;
      else if (i_byte_received)
        r_bit_cnt <= i_shift_enable ? 3'd1 : 3'd0;
      else if (i_shift_enable && !i_eop)
        r_bit_cnt <= r_bit_cnt + 3'd1;

      // ERR_WAIT must see EOP high before its falling edge releases the bus
      if (w_start)
        r_eop_seen <= 1'b0;
      else if (w_err)
        r_eop_seen <= i_eop;
      else if (r_state == S_ERR_WAIT && i_eop)
        r_eop_seen <= 1'b1;
    end
  end

  assign o_rx_transfer_active   = r_active;
  assign o_flush                = r_flush;
  assign o_store_rx_packet_data = r_store;
  assign o_rx_packet_data       = r_data;
  assign o_rx_packet            = r_packet;
  assign o_rx_packet_done       = r_done;
  assign o_rx_error             = r_error;

endmodule

// File: doc/usb_rx_controller.md
# usb_rx_controller

- Packet-level sequencer for the USB receive path.
- Starts and stops the bit/byte timer through `rx_transfer_active`.
- Checks each byte as the shift register completes it: sync byte, then PID, then payload bytes.
- Detects framing errors and passes PID codes, payload bytes and completion/error status to the protocol layer and the RX FIFO.

## Interface
- MAX_DATA, 66: max post-PID bytes in a DATA packet (64 payload + 2 CRC16)
- SYNC_BYTE, 8'h80: required first byte as presented on `rcv_data`
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- d_edge  in  1  1-cycle pulse on any D+/D- transition (from edge detector)
- eop  in  1  level, SE0 present on bus
- shift_enable  in  1  1-cycle bit-sample strobe from timer
- byte_received  in  1  1-cycle pulse, `rcv_data` holds a complete byte
- rcv_data  in  8  current shift-register contents
- rx_transfer_active  out  1  enables timer; high from packet start through EOP
- flush  out  1  1-cycle pulse at packet start, clears RX FIFO
- store_rx_packet_data  out  1  1-cycle FIFO write strobe
- rx_packet_data  out  8  byte to FIFO, valid with store strobe
- rx_packet  out  3  PID code: 0 none, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 STALL
- rx_packet_done  out  1  1-cycle pulse, good packet complete
- rx_error  out  1  level, last packet malformed

## Operation
- **States:** IDLE, SYNC, PID, TOKEN, DATA, HSK, EOP_WAIT, ERR_WAIT.
- **IDLE:** on `d_edge`, go to SYNC. Set `rx_transfer_active`=1, pulse `flush`, clear `rx_error`, `rx_packet`=0 and the byte counter.
- **SYNC:** on `byte_received`, go to PID if `rcv_data`==SYNC_BYTE, else error.
- **PID check:** on `byte_received`, require `rcv_data[7:4]`==~`rcv_data[3:0]`.
- **PID decode** of the full byte:
  - E1 → OUT(1), 69 → IN(2); next state TOKEN.
  - C3 → DATA0(3), 4B → DATA1(4); next state DATA.
  - D2 → ACK(5), 5A → NAK(6), 1E → STALL(7); next state HSK.
  - Any other byte, or a failed complement check: error.
  - `rx_packet` is registered on the PID-accept cycle.
- **TOKEN:** count bytes; none are stored.
- **DATA:**
  - Each `byte_received` copies `rcv_data` to `rx_packet_data`, pulses `store_rx_packet_data` and increments the 7-bit byte counter.
  - The byte that would make count > MAX_DATA is an error and is not stored.
- **HSK:** any `byte_received` is an error.
- **Bit tracking:** a 3-bit `bit_cnt` increments on `shift_enable` with `eop`=0 and clears on `byte_received`.
  - If `byte_received` and `shift_enable` coincide, `bit_cnt` loads 1.
- **EOP acceptance** (in PID/TOKEN/DATA/HSK, when `shift_enable`&&`eop`):
  - Rejected if `bit_cnt`≠0: error.
  - Rejected if seen in PID state: error.
  - Rejected on a length mismatch: error. Required lengths are TOKEN count==2, DATA 2≤count≤MAX_DATA, HSK count==0.
  - Otherwise accepted: pulse `rx_packet_done`, go to EOP_WAIT.
- **EOP in SYNC:** error.
- **EOP_WAIT:** when `eop`==0, drop `rx_transfer_active` and go to IDLE.
- **Error:** `rx_error`←1, `rx_packet`←0, go to ERR_WAIT.
  - ERR_WAIT keeps `rx_transfer_active`=1 and performs no stores.
  - It returns to IDLE after `eop` has been seen high and then low.
- **Precedence:** `rst` overrides everything. Then `byte_received` is processed before the EOP check in the same cycle. `d_edge` is ignored outside IDLE.

## Timing
- All outputs registered.
- Reset values: `rx_transfer_active`=0, `flush`=0, `store_rx_packet_data`=0, `rx_packet_data`=0, `rx_packet`=0, `rx_packet_done`=0, `rx_error`=0; state IDLE, counters 0.
- `rst` applied mid-packet forces the reset values on the next edge. The following `d_edge` starts a fresh packet.
- `flush` and `rx_transfer_active` rise 1 cycle after the IDLE `d_edge`.
- `store_rx_packet_data` and `rx_packet_data` are valid 1 cycle after `byte_received`.
- `rx_packet` is updated 1 cycle after the PID `byte_received`. It is held until the next packet start or an error.
- `rx_packet_done` is asserted 1 cycle after the accepting `shift_enable`.
- `rx_error` is set 1 cycle after the detecting event and held until the next packet start.
- `rx_transfer_active` falls 1 cycle after `eop` deasserts in EOP_WAIT/ERR_WAIT.

## Test plan
- **ACK packet:** sync 80, byte D2, EOP on byte boundary → `rx_packet`=5, one `rx_packet_done` pulse, no stores, `rx_error`=0, `rx_transfer_active` low after EOP ends.
- **DATA1 packet:** sync, 4B, bytes 11 22 33 44, EOP → four `store_rx_packet_data` pulses with data 11,22,33,44; `rx_packet`=4; `rx_packet_done` pulses.
- **Bad framing:** first byte 00 → `rx_error`=1, `rx_packet`=0. Separately, PID C4 (complement fail) → `rx_error`=1. In both cases no stores, and `rx_transfer_active` is held until EOP ends.
- **Misplaced EOP:** OUT token, one byte, then EOP with `bit_cnt`=3 → `rx_error`=1. Separately, OUT token with 3 bytes → `rx_error`=1 at EOP.
- **Overflow:** DATA0 with 67 post-PID bytes → exactly 66 stores, `rx_error`=1 on the 67th byte.
- **Reset and restart:** `rst` pulse mid-DATA → all outputs 0 next cycle. Then an ACK packet followed by a new `d_edge` → `flush` pulse, `rx_error` cleared, second packet decoded normally.
